// File: rtl/dram_req_queue_if.sv
// rtl/dram_req_queue_if.sv - host request/response and controller user-port bundle
interface dram_req_queue_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 2
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_cmd;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_data;
  logic                  c_en;
  logic [ADDR_WIDTH-1:0] c_addr;
  logic                  c_cmd;
  logic [DATA_WIDTH-1:0] c_data_i;
  logic                  c_cmd_ack;
  logic                  c_busy;
  logic [DATA_WIDTH-1:0] c_data_o;
  logic                  c_data_valid;

  // the queue itself
  modport slave (
    input  req_valid, req_cmd, req_addr, req_wdata, rsp_ready,
    input  c_cmd_ack, c_busy, c_data_o, c_data_valid,
    output req_ready, rsp_valid, rsp_data, c_en, c_addr, c_cmd, c_data_i
  );

  // host plus controller side, as seen from outside the queue
  modport master (
    output req_valid, req_cmd, req_addr, req_wdata, rsp_ready,
    output c_cmd_ack, c_busy, c_data_o, c_data_valid,
    input  req_ready, rsp_valid, rsp_data, c_en, c_addr, c_cmd, c_data_i
  );
endinterface

// File: rtl/dram_req_queue.sv
// rtl/dram_req_queue.sv - DRAM request queue, issue FSM and credit-protected response buffer
module dram_req_queue #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 2,
  parameter int CMD_DEPTH  = 4,
  parameter int RSP_DEPTH  = 4
) (
  input  logic                         u_clk,
  input  logic                         u_rst_n,
  dram_req_queue_if.slave              bus,
  output logic [$clog2(CMD_DEPTH):0]   cmd_level,
  output logic                         idle
);
  localparam int CPW = $clog2(CMD_DEPTH);
  localparam int RPW = $clog2(RSP_DEPTH);
  localparam int EW  = 1 + ADDR_WIDTH + DATA_WIDTH;
  localparam logic [CPW:0]   CMD_FULL = (CPW+1)'(CMD_DEPTH);
  localparam logic [RPW+1:0] RSP_LIM  = (RPW+2)'(RSP_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

  state_t state, state_nxt;

  logic [EW-1:0]         cmd_mem [CMD_DEPTH];
  logic [CPW-1:0]        cmd_wr_ptr, cmd_rd_ptr;
  logic [CPW:0]          cmd_count;
  logic [DATA_WIDTH-1:0] rsp_mem [RSP_DEPTH];
  logic [RPW-1:0]        rsp_wr_ptr, rsp_rd_ptr;
  logic [RPW:0]          rsp_count;
  logic [RPW:0]          rd_inflight;
  logic [RPW+1:0]        credit_used;
  logic [EW-1:0]         head;
  logic                  cmd_empty;
  logic                  cmd_push, cmd_pop;
  logic                  rsp_push, rsp_pop;
  logic                  head_is_read, head_issuable;

  assign cmd_empty     = (cmd_count == '0);
  assign bus.req_ready = (cmd_count != CMD_FULL);
  assign cmd_push      = bus.req_valid && bus.req_ready;
  assign cmd_pop       = (state == S_WAIT) && bus.c_cmd_ack && !cmd_empty;

  // The controller re-reads the user port live, so the head is shown
  // unregistered and forced to zero when nothing is queued.
  assign head = cmd_empty ? '0 : cmd_mem[cmd_rd_ptr];
  assign {bus.c_cmd, bus.c_addr, bus.c_data_i} = head;

  // A read may only leave once a response slot is guaranteed for it.
  assign head_is_read  = !head[EW-1];
  assign credit_used   = {1'b0, rsp_count} + {1'b0, rd_inflight};
  assign head_issuable = !head_is_read || (credit_used < RSP_LIM);

  // Enable covers controller-internal sequences (busy) as well as our own issue.
  assign bus.c_en = bus.c_busy | (state != S_IDLE);

  assign rsp_push      = bus.c_data_valid && (rd_inflight != '0);
  assign rsp_pop       = bus.rsp_valid && bus.rsp_ready;
  assign bus.rsp_valid = (rsp_count != '0);
  assign bus.rsp_data  = bus.rsp_valid ? rsp_mem[rsp_rd_ptr] : '0;

  assign cmd_level = cmd_count;
  assign idle      = cmd_empty && (state == S_IDLE) && (rd_inflight == '0) && !bus.c_busy;

  // Issue state register
  always_ff @(posedge u_clk or negedge u_rst_n) begin
    if (!u_rst_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // Issue next-state: hold the head from ISSUE through the ack cycle
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (!cmd_empty && !bus.c_busy && head_issuable) state_nxt = S_ISSUE;
      S_ISSUE: state_nxt = S_WAIT;
      S_WAIT:  if (bus.c_cmd_ack) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Command FIFO storage; empty entries are masked on the output side
  always_ff @(posedge u_clk) begin
    if (cmd_push) cmd_mem[cmd_wr_ptr] <= {bus.req_cmd, bus.req_addr, bus.req_wdata};
  end

  // Command FIFO pointers and occupancy
  always_ff @(posedge u_clk or negedge u_rst_n) begin
    if (!u_rst_n) begin
      cmd_wr_ptr <= '0;
      cmd_rd_ptr <= '0;
      cmd_count  <= '0;
    end else begin
      if (cmd_push) cmd_wr_ptr <= cmd_wr_ptr + CPW'(1);
      if (cmd_pop)  cmd_rd_ptr <= cmd_rd_ptr + CPW'(1);
      case ({cmd_push, cmd_pop})
        2'b10:   cmd_count <= cmd_count + (CPW+1)'(1);
        2'b01:   cmd_count <= cmd_count - (CPW+1)'(1);
        default: cmd_count <= cmd_count;
      endcase
    end
  end

  // Response FIFO storage
  always_ff @(posedge u_clk) begin
    if (rsp_push) rsp_mem[rsp_wr_ptr] <= bus.c_data_o;
  end

  // Response FIFO pointers, occupancy and outstanding-read credits
  always_ff @(posedge u_clk or negedge u_rst_n) begin
    if (!u_rst_n) begin
      rsp_wr_ptr  <= '0;
      rsp_rd_ptr  <= '0;
      rsp_count   <= '0;
      rd_inflight <= '0;
    end else begin
      if (rsp_push) rsp_wr_ptr <= rsp_wr_ptr + RPW'(1);
      if (rsp_pop)  rsp_rd_ptr <= rsp_rd_ptr + RPW'(1);
      case ({rsp_push, rsp_pop})
        2'b10:   rsp_count <= rsp_count + (RPW+1)'(1);
        2'b01:   rsp_count <= rsp_count - (RPW+1)'(1);
        default: rsp_count <= rsp_count;
      endcase
      case ({cmd_pop && head_is_read, rsp_push})
        2'b10:   rd_inflight <= rd_inflight + (RPW+1)'(1);
        2'b01:   rd_inflight <= rd_inflight - (RPW+1)'(1);
        default: rd_inflight <= rd_inflight;
      endcase
    end
  end
endmodule

// File: tb/tb_dram_req_queue.sv
// tb/tb_dram_req_queue.sv - self-checking bench for dram_req_queue
module tb_dram_req_queue;
  localparam int AW = 12;
  localparam int DW = 2;
  localparam int CD = 4;
  localparam int RD = 4;

  logic u_clk = 1'b0;
  logic u_rst_n = 1'b0;
  logic [$clog2(CD):0] cmd_level;
  logic idle;

  dram_req_queue_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  dram_req_queue #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CMD_DEPTH(CD), .RSP_DEPTH(RD)) dut (
    .u_clk    (u_clk),
    .u_rst_n  (u_rst_n),
    .bus      (bus),
    .cmd_level(cmd_level),
    .idle     (idle)
  );

  always #5 u_clk = ~u_clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Controller's read data is a fixed function of the address.
  function automatic logic [DW-1:0] rd_fn(input logic [AW-1:0] a);
    return a[1:0] ^ a[7:6] ^ 2'b10;
  endfunction

  // Reference model: accepted requests in order, expected responses in order.
  typedef struct packed {
    logic          cmd;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } req_t;

  req_t          iss_q[$];
  logic [DW-1:0] rsp_q[$];
  int            m_cmd, m_inflight, m_avail, n_acks, n_rsp;
  logic [DW-1:0] last_rsp;
  bit            mon_en = 1'b0;

  task automatic model_reset();
    iss_q.delete();
    rsp_q.delete();
    m_cmd = 0; m_inflight = 0; m_avail = 0;
  endtask

  // Scoreboard: outputs checked mid-cycle, then the coming edge's handshakes applied.
  always @(negedge u_clk) begin
    if (mon_en && u_rst_n) begin
      chk("cmd_level", cmd_level, m_cmd);
      chk("req_ready", bus.req_ready, m_cmd < CD);
      chk("rsp_valid", bus.rsp_valid, m_avail > 0);
      chk("credit_bound", (m_inflight + m_avail) <= RD, 1);
      if (m_cmd == 0) chk("head_zero", {bus.c_cmd, bus.c_addr, bus.c_data_i}, 0);
      if (m_avail == 0) chk("rsp_data_zero", bus.rsp_data, 0);
      if (bus.req_valid && bus.req_ready) begin
        iss_q.push_back('{bus.req_cmd, bus.req_addr, bus.req_wdata});
        m_cmd++;
      end
      if (bus.c_cmd_ack && bus.c_en) begin
        chk("ack_has_entry", iss_q.size() > 0, 1);
        if (iss_q.size() > 0) begin
          chk("issue_cmd", bus.c_cmd, iss_q[0].cmd);
          chk("issue_addr", bus.c_addr, iss_q[0].addr);
          if (iss_q[0].cmd) chk("issue_wdata", bus.c_data_i, iss_q[0].wdata);
          else begin
            rsp_q.push_back(rd_fn(iss_q[0].addr));
            m_inflight++;
          end
          void'(iss_q.pop_front());
          m_cmd--;
          n_acks++;
        end
      end
      if (bus.c_data_valid && m_inflight > 0) begin
        m_inflight--;
        m_avail++;
      end
      if (bus.rsp_valid && bus.rsp_ready && rsp_q.size() > 0) begin
        chk("rsp_data", bus.rsp_data, rsp_q[0]);
        last_rsp = rsp_q[0];
        void'(rsp_q.pop_front());
        m_avail--;
        n_rsp++;
      end
    end
  end

  // Controller model: samples in ISSUE, acks next cycle, then busy for 1..4 cycles.
  bit            ctrl_auto = 1'b0;
  int            ctrl_phase = 0;
  int            ctrl_timer = 0;
  logic          ctrl_cmd;
  logic [AW-1:0] ctrl_addr;

  initial begin
    forever begin
      @(posedge u_clk); #1;
      if (ctrl_auto && u_rst_n) begin
        bus.c_cmd_ack = 1'b0;
        bus.c_data_valid = 1'b0;
        case (ctrl_phase)
          0: if (bus.c_en && !bus.c_busy) ctrl_phase = 1;
          1: begin
            bus.c_cmd_ack = 1'b1;
            ctrl_cmd = bus.c_cmd;
            ctrl_addr = bus.c_addr;
            ctrl_phase = 2;
          end
          2: begin
            bus.c_busy = 1'b1;
            ctrl_timer = $urandom_range(1, 4);
            ctrl_phase = 3;
          end
          default: begin
            if (ctrl_timer > 1) ctrl_timer--;
            else begin
              if (!ctrl_cmd) begin
                bus.c_data_valid = 1'b1;
                bus.c_data_o = rd_fn(ctrl_addr);
              end
              bus.c_busy = 1'b0;
              ctrl_phase = 0;
            end
          end
        endcase
      end
    end
  end

  // Called at posedge+#1; returns at posedge+#1 after the accepting edge.
  task automatic push_req(input logic c, input logic [AW-1:0] a, input logic [DW-1:0] d, input int budget);
    bus.req_valid = 1'b1; bus.req_cmd = c; bus.req_addr = a; bus.req_wdata = d;
    for (int i = 0; i < budget; i++) begin
      @(negedge u_clk);
      if (bus.req_ready) begin
        @(posedge u_clk); #1;
        bus.req_valid = 1'b0;
        return;
      end
      @(posedge u_clk); #1;
    end
    chk("push_timeout", bus.req_ready, 1);
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_drain(input string nm, input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge u_clk);
      if (iss_q.size() == 0 && rsp_q.size() == 0 && idle) begin ok = 1'b1; break; end
    end
    chk(nm, idle && ok, 1);
  endtask

  typedef struct packed {
    logic          cmd;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          has_rsp;
    logic [DW-1:0] rsp;
  } vec_t;

  vec_t vecs[7];
  int   en_cycles, first_en, rsp0, acks0;
  bit   dv_prev, found;
  int   en_seen;

  initial begin
    vecs[0] = '{1'b1, 12'h1A5, 2'b10, 1'b0, 2'b00};
    vecs[1] = '{1'b0, 12'h040, 2'b00, 1'b1, 2'b11};
    vecs[2] = '{1'b0, 12'hFFF, 2'b00, 1'b1, 2'b10};
    vecs[3] = '{1'b1, 12'h800, 2'b01, 1'b0, 2'b00};
    vecs[4] = '{1'b0, 12'h0C2, 2'b00, 1'b1, 2'b11};
    vecs[5] = '{1'b0, 12'h3C1, 2'b00, 1'b1, 2'b00};
    vecs[6] = '{1'b1, 12'hFFF, 2'b11, 1'b0, 2'b00};

    bus.req_valid = 0; bus.req_cmd = 0; bus.req_addr = 0; bus.req_wdata = 0;
    bus.rsp_ready = 1; bus.c_cmd_ack = 0; bus.c_busy = 0; bus.c_data_o = 0; bus.c_data_valid = 0;
    model_reset(); n_acks = 0; n_rsp = 0; last_rsp = 0;

    // Reset values, with busy low then high
    #12;
    chk("rst_c_en", bus.c_en, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_rsp_data", bus.rsp_data, 0);
    chk("rst_head", {bus.c_cmd, bus.c_addr, bus.c_data_i}, 0);
    chk("rst_cmd_level", cmd_level, 0);
    chk("rst_idle", idle, 1);
    bus.c_busy = 1'b1; #1;
    chk("rst_c_en_busy", bus.c_en, 1);
    chk("rst_idle_busy", idle, 0);
    @(negedge u_clk); u_rst_n = 1'b1; mon_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge u_clk);
      chk("post_rst_c_en", bus.c_en, 1);
      chk("post_rst_req_ready", bus.req_ready, 1);
    end
    @(posedge u_clk); #1 bus.c_busy = 1'b0;
    @(negedge u_clk);
    chk("busy_drop_c_en", bus.c_en, 0);
    chk("busy_drop_idle", idle, 1);

    // Command FIFO full with a busy controller
    @(posedge u_clk); #1 bus.c_busy = 1'b1;
    push_req(1'b1, 12'h111, 2'b01, 4);
    push_req(1'b0, 12'h222, 2'b00, 4);
    push_req(1'b1, 12'h333, 2'b11, 4);
    push_req(1'b0, 12'h044, 2'b00, 4);
    @(negedge u_clk);
    chk("full_req_ready", bus.req_ready, 0);
    @(posedge u_clk); #1;
    bus.req_valid = 1'b1; bus.req_cmd = 1'b1; bus.req_addr = 12'h555; bus.req_wdata = 2'b10;
    repeat (3) begin @(negedge u_clk); chk("full_hold_ready", bus.req_ready, 0); end
    @(posedge u_clk); #1 bus.c_busy = 1'b0;
    found = 1'b0;
    for (int t = 0; t < 10; t++) begin
      @(negedge u_clk);
      if (bus.c_en) begin found = 1'b1; break; end
    end
    chk("full_issue_seen", found, 1);
    chk("full_issue_addr", bus.c_addr, 12'h111);
    @(posedge u_clk); #1 bus.c_cmd_ack = 1'b1;
    @(negedge u_clk);
    chk("full_no_passthru", bus.req_ready, 0);
    @(posedge u_clk); #1 bus.c_cmd_ack = 1'b0; bus.c_busy = 1'b1;
    @(negedge u_clk);
    chk("full_ready_after_pop", bus.req_ready, 1);
    chk("full_level_after_pop", cmd_level, 3);
    @(posedge u_clk); #1 bus.req_valid = 1'b0;
    @(negedge u_clk);
    chk("full_fifth_accepted", cmd_level, 4);
    repeat (3) begin @(negedge u_clk); chk("lockout_busy_c_en", bus.c_en, 1); end
    bus.c_busy = 1'b0; ctrl_phase = 0; ctrl_auto = 1'b1; #1;
    chk("lockout_c_en", bus.c_en, 0);
    wait_drain("full_drain", 200);

    // Table-driven single transactions
    for (int k = 0; k < 7; k++) begin
      rsp0 = n_rsp; en_cycles = 0; first_en = -1; dv_prev = 1'b0;
      @(posedge u_clk); #1;
      push_req(vecs[k].cmd, vecs[k].addr, vecs[k].wdata, 4);
      for (int t = 0; t < 8; t++) begin
        @(negedge u_clk);
        if (t == 0) chk("v_level_one", cmd_level, 1);
        if (bus.c_busy) break;
        if (bus.c_en) begin
          en_cycles++;
          if (first_en < 0) first_en = t;
          chk("v_c_addr", bus.c_addr, vecs[k].addr);
          chk("v_c_cmd", bus.c_cmd, vecs[k].cmd);
          if (vecs[k].cmd) chk("v_c_data_i", bus.c_data_i, vecs[k].wdata);
        end
      end
      chk("v_en_cycles", en_cycles, 2);
      chk("v_first_issue", first_en, 1);
      chk("v_level_zero", cmd_level, 0);
      for (int t = 0; t < 20; t++) begin
        @(negedge u_clk);
        if (dv_prev) begin
          chk("v_rsp_valid_lat", bus.rsp_valid, 1);
          chk("v_rsp_data", bus.rsp_data, vecs[k].rsp);
        end
        dv_prev = bus.c_data_valid;
      end
      chk("v_rsp_count", n_rsp - rsp0, vecs[k].has_rsp);
      if (vecs[k].has_rsp) chk("v_last_rsp", last_rsp, vecs[k].rsp);
      chk("v_idle", idle, 1);
    end

    // Credit stall: 6 reads, host not accepting
    bus.rsp_ready = 1'b0; acks0 = n_acks; rsp0 = n_rsp;
    @(posedge u_clk); #1;
    for (int i = 0; i < 6; i++) push_req(1'b0, 12'h300 + 12'(i), 2'b00, 40);
    repeat (40) @(negedge u_clk);
    chk("credit_issued", n_acks - acks0, 4);
    en_seen = 0;
    for (int t = 0; t < 10; t++) begin @(negedge u_clk); if (bus.c_en) en_seen++; end
    chk("credit_c_en_quiet", en_seen, 0);
    chk("credit_level", cmd_level, 2);
    @(posedge u_clk); #1 bus.rsp_ready = 1'b1;
    @(posedge u_clk); #1 bus.rsp_ready = 1'b0;
    repeat (30) @(negedge u_clk);
    chk("credit_one_more", n_acks - acks0, 5);
    @(posedge u_clk); #1 bus.rsp_ready = 1'b1;
    wait_drain("credit_drain", 200);
    chk("credit_all_rsp", n_rsp - rsp0, 6);

    // Randomized traffic against the scoreboard
    rsp0 = n_rsp;
    for (int c = 0; c < 3000; c++) begin
      @(posedge u_clk); #1;
      bus.req_valid = ($urandom_range(0, 2) != 0);
      bus.req_cmd = $urandom_range(0, 1);
      bus.req_addr = AW'($urandom);
      bus.req_wdata = DW'($urandom);
      bus.rsp_ready = (c < 1500) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
    end
    @(posedge u_clk); #1 bus.req_valid = 1'b0; bus.rsp_ready = 1'b1;
    wait_drain("rand_drain", 500);
    chk("rand_some_rsp", n_rsp > rsp0, 1);

    // Asynchronous reset in WAIT, then a stray data pulse
    @(negedge u_clk); ctrl_auto = 1'b0;
    @(posedge u_clk); #1;
    push_req(1'b0, 12'h0AB, 2'b00, 4);
    found = 1'b0;
    for (int t = 0; t < 10; t++) begin
      @(negedge u_clk);
      if (bus.c_en) begin found = 1'b1; break; end
    end
    chk("arst_issue_seen", found, 1);
    @(negedge u_clk);
    chk("arst_wait_c_en", bus.c_en, 1);
    mon_en = 1'b0; u_rst_n = 1'b0; #1;
    chk("arst_c_en", bus.c_en, 0);
    chk("arst_cmd_level", cmd_level, 0);
    chk("arst_rsp_valid", bus.rsp_valid, 0);
    model_reset();
    @(negedge u_clk); u_rst_n = 1'b1; mon_en = 1'b1;
    @(posedge u_clk); #1 bus.c_data_valid = 1'b1; bus.c_data_o = 2'b11;
    @(posedge u_clk); #1 bus.c_data_valid = 1'b0;
    for (int t = 0; t < 10; t++) begin
      @(negedge u_clk);
      chk("arst_no_rsp", bus.rsp_valid, 0);
    end
    chk("arst_idle", idle, 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end
endmodule
